lcd_gray_stream: RTL and testbench
==================================

# lcd_gray_stream

Parametrised streaming controller for UC16xx-class grayscale LCD panels. It sits between the PPU pixel output (`px_out`, `px`, `hsync`, `vsync`) and the LCD 8-bit parallel bus. It generalises the fixed 4-bpp panel driver in five ways:
- configurable bits per pixel;
- runtime-writable 4-entry palette;
- external init-command ROM of any length;
- programmable write-strobe width;
- 2-entry byte buffer with a sticky overflow flag.

## Interface
- `BPP`, default 4: panel bits per pixel; legal values 1, 2, 4, 8. PPB = 8/BPP pixels per byte.
- `INIT_LEN`, default 16: number of init commands (≥ 2).
- `REINIT_IDX`, default 12: init index restarted at each frame (`vsync`); must be < INIT_LEN.
- `WAIT_CYCLES`, default 49152: power-up delay before the first command (≥ 1).
- `WR_CYCLES`, default 1: cycles `lcd_write` is high, then low, per byte (≥ 1).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `disp_on` in 1: display enable.
- `hsync`, `vsync`, `px_out` in 1: PPU line start, frame start, pixel valid.
- `px` in 2: PPU colour index.
- `pal_we` in 1: palette write strobe.
- `pal_idx` in 2: palette entry to write.
- `pal_data` in BPP: palette value.
- `init_addr` out clog2(INIT_LEN): index into the external init ROM.
- `init_data` in 8: ROM byte at `init_addr`, combinational.
- `lcd_data` out 8: LCD data bus.
- `lcd_write` out 1: LCD write strobe.
- `lcd_cd` out 1: 0 = command, 1 = display data.
- `lcd_read` out 1: constant 0.
- `lcd_cs` out 1: constant 1.
- `lcd_vled` out 1: equals `disp_on`.
- `overflow` out 1: sticky flag, set when a packed byte is dropped.

## Operation
**Top-level states:** OFF, WAIT, INIT, ON, UNINIT.

**OFF**
- `lcd_write` = 0.
- When `disp_on` = 1: go to WAIT, clear the delay counter, set `insync` = 1, clear `overflow`, empty the buffer, clear the partial-pixel count.

**WAIT**
- Count WAIT_CYCLES cycles, then go to INIT with index 0.

**INIT**
- One command per index: `init_addr` = index, `lcd_data` = `init_data`, `lcd_cd` = 0.
- Strobe: `lcd_write` high for WR_CYCLES cycles, then low for WR_CYCLES cycles.
- After index INIT_LEN-1 completes, go to ON.
- While in INIT, `insync` tracking: `vsync` sets it; otherwise `hsync` or `px_out` clears it.

**ON**
- If `insync` = 0, pixels are ignored until `vsync`.
- If `insync` = 1, each `px_out` maps `px` through the palette into a BPP-bit value.
- Packing: the first pixel of a byte goes in bits [BPP-1:0], the next pixel in the next-higher field, and so on.
- After PPB pixels, the byte is pushed into a 2-entry FIFO.
- If the FIFO is full at push time, the byte is dropped and `overflow` is set.
- The write engine pops the FIFO whenever it is idle and drives the byte with `lcd_cd` = 1, using the same 2×WR_CYCLES strobe as INIT.

**vsync in ON**
- Discard the partial byte and the FIFO contents; this does not set `overflow`.
- Ignore further pixels.
- Any strobe in progress completes.
- Then go to INIT at REINIT_IDX with `insync` = 1.

**`disp_on` = 0 in ON**
- Same flush and wait for the strobe to complete.
- Then UNINIT: send command 0xE2 (one strobe, `lcd_cd` = 0), then go to OFF.
- If `vsync` and `disp_on` = 0 arrive together, `disp_on` = 0 wins.
- `disp_on` dropping in WAIT or INIT finishes the current strobe, then goes to UNINIT.

**Palette**
- `pal_we` writes take effect on the next cycle and are legal in any state.
- Reset value of entry i is floor(i·(2^BPP−1)/3); for BPP=4 this gives 0, 5, 10, 15.

## Timing
- **Reset values:** state OFF; `lcd_write` 0; `lcd_cd` 0; `lcd_data` 0x00; `init_addr` 0; `overflow` 0; FIFO empty; palette at defaults.
- **Outputs:** all registered; `lcd_data` and `lcd_cd` are stable for the whole 2×WR_CYCLES byte window.
- **First command:** the strobe for command 0 rises WAIT_CYCLES+1 cycles after the `disp_on` sample.
- **Init duration:** INIT_LEN·2·WR_CYCLES cycles.
- **Pixel latency:** the strobe for a completed byte rises 2 cycles after the `px_out` that completes it, provided the engine is idle.
- **Sustained rate:** at most 1 byte per 2·WR_CYCLES cycles. Pixels arriving faster than PPB per 2·WR_CYCLES cycles eventually overflow.
- **Reset mid-operation:** same-cycle return to the reset values; `lcd_write` is 0 on the next edge.

## Test plan
- **Power-up sequence** (BPP=4, WR_CYCLES=1, WAIT_CYCLES=8, INIT_LEN=16, ROM[i]=0x10+i): raise `disp_on` → 16 strobes, `lcd_cd`=0, data 0x10..0x1F; first strobe rises 9 cycles after `disp_on`.
- **Pixel packing:** `vsync` then `px` = 1, 2 → one byte 0xA5 with `lcd_cd`=1. With BPP=2, `px` = 3, 0, 1, 2 → 0x93 (palette 0, 1, 2, 3).
- **Palette write:** write `pal_idx`=2, `pal_data`=0x7; send pixels 2, 2 → 0x77.
- **Overflow:** WR_CYCLES=4, `px_out` every cycle → after the FIFO fills, `overflow`=1 and only complete bytes appear on the bus; `overflow` clears on the next OFF→WAIT.
- **Frame restart:** `vsync` in ON with one pending pixel → no partial byte is emitted; ROM indices 12..15 are re-sent, then pixel bytes resume.
- **Shutdown:** drop `disp_on` in ON → in-flight strobe completes, a 0xE2 command strobe follows, state returns to OFF, `lcd_vled`=0 immediately; `reset` asserted mid-INIT → `lcd_write`=0 on the next edge.

Source files
------------

// File: rtl/lcd_gray_stream.sv
// lcd_gray_stream: PPU pixel stream to UC16xx grayscale LCD bus, with palette, init ROM sequencing and byte FIFO.
module lcd_gray_stream #(
  parameter int BPP         = 4,
  parameter int INIT_LEN    = 16,
  parameter int REINIT_IDX  = 12,
  parameter int WAIT_CYCLES = 49152,
  parameter int WR_CYCLES   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        disp_on,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic                        px_out,
  input  logic [1:0]                  px,
  input  logic                        pal_we,
  input  logic [1:0]                  pal_idx,
  input  logic [BPP-1:0]              pal_data,
  output logic [$clog2(INIT_LEN)-1:0] init_addr,
  input  logic [7:0]                  init_data,
  output logic [7:0]                  lcd_data,
  output logic                        lcd_write,
  output logic                        lcd_cd,
  output logic                        lcd_read,
  output logic                        lcd_cs,
  output logic                        lcd_vled,
  output logic                        overflow
);
  localparam int AW  = $clog2(INIT_LEN);
  localparam int PPB = 8 / BPP;
  localparam int PW  = PPB > 1 ? $clog2(PPB) : 1;
  localparam int WW  = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  localparam int CW  = $clog2(2 * WR_CYCLES);

  typedef enum logic [2:0] {OFF, WAIT, INIT, ON, UNINIT} state_t;

  state_t         state_q, state_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  pc_q, pc_d;
  logic [BPP-1:0] pp_q, pp_d;
  logic [BPP-1:0] pal_q [4];
  logic [BPP-1:0] pal_d [4];
  logic [7:0]     mem_q [2];
  logic [7:0]     mem_d [2];
  logic [7:0]     data_q, data_d, acc_q, acc_d, byte_w, sdata;
  logic [1:0]     fc_q, fc_d;
  logic           last_q, last_d, busy_q, busy_d, wr_q, wr_d, cd_q, cd_d;
  logic           insync_q, insync_d, ovf_q, ovf_d, vs_q, vs_d, pv_q, pv_d;
  logic           rd_q, rd_d, wp_q, wp_d;
  logic           done, free, flush, push, pushed, pop, start, scd, halt;

  assign done   = busy_q && cnt_q == CW'(2 * WR_CYCLES - 1);
  assign free   = !busy_q || done;
  assign flush  = state_q == ON && (vs_q || vsync || !disp_on);
  assign byte_w = acc_q | (8'(pp_q) << (pc_q * BPP));
  assign push   = pv_q && !flush && pc_q == PW'(PPB - 1);

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    idx_d    = idx_q;
    last_d   = last_q;
    insync_d = insync_q;
    ovf_d    = ovf_q;
    vs_d     = vs_q;
    start    = 1'b0;
    sdata    = init_data;
    scd      = 1'b0;
    pop      = 1'b0;
    halt     = 1'b0;
    case (state_q)
      OFF: if (disp_on) begin
        state_d  = WAIT;
        wait_d   = '0;
        insync_d = 1'b1;
        ovf_d    = 1'b0;
      end
      WAIT: if (!disp_on) halt = 1'b1;
        else if (wait_q == WW'(WAIT_CYCLES - 1)) begin
          state_d = INIT;
          idx_d   = '0;
          last_d  = 1'b0;
        end else wait_d = wait_q + 1'b1;
      INIT: begin
        insync_d = vsync || (insync_q && !hsync && !px_out);
        if (free && !disp_on) halt = 1'b1;
        else if (done && last_q) state_d = ON;
        else if (free) begin
          // init_addr runs one index ahead so the next ROM byte is ready at strobe end
          start  = 1'b1;
          last_d = idx_q == AW'(INIT_LEN - 1);
          idx_d  = last_d ? idx_q : idx_q + 1'b1;
        end
      end
      ON: begin
        vs_d = flush;
        if (flush && free) begin
          vs_d = 1'b0;
          if (!disp_on) halt = 1'b1;
          else begin
            state_d  = INIT;
            idx_d    = AW'(REINIT_IDX);
            last_d   = 1'b0;
            insync_d = 1'b1;
          end
        end else if (!flush && free && fc_q != 2'd0) begin
          pop   = 1'b1;
          start = 1'b1;
          sdata = mem_q[rd_q];
          scd   = 1'b1;
        end
      end
      UNINIT: if (done) state_d = OFF;
      default: state_d = OFF;
    endcase
    if (halt) begin
      state_d = UNINIT;
      start   = 1'b1;
      sdata   = 8'hE2;
      scd     = 1'b0;
    end
    busy_d = busy_q;
    cnt_d  = cnt_q;
    wr_d   = wr_q;
    data_d = data_q;
    cd_d   = cd_q;
    if (busy_q) begin
      cnt_d  = cnt_q + 1'b1;
      wr_d   = cnt_q == CW'(WR_CYCLES - 1) ? 1'b0 : wr_q;
      busy_d = !done;
    end
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      wr_d   = 1'b1;
      data_d = sdata;
      cd_d   = scd;
    end
    pv_d   = px_out && state_q == ON && insync_q && !flush;
    pp_d   = pal_q[px];
    pal_d  = pal_q;
    if (pal_we) pal_d[pal_idx] = pal_data;
    mem_d  = mem_q;
    rd_d   = rd_q ^ pop;
    wp_d   = wp_q;
    acc_d  = acc_q;
    pc_d   = pc_q;
    pushed = 1'b0;
    if (push) begin
      acc_d = '0;
      pc_d  = '0;
      if (fc_q == 2'd2 && !pop) ovf_d = 1'b1;
      else begin
        mem_d[wp_q] = byte_w;
        wp_d        = !wp_q;
        pushed      = 1'b1;
      end
    end else if (pv_q && !flush) begin
      acc_d = byte_w;
      pc_d  = pc_q + 1'b1;
    end
    fc_d = fc_q + {1'b0, pushed} - {1'b0, pop};
    if (flush || state_q == OFF) begin
      fc_d  = '0;
      rd_d  = 1'b0;
      wp_d  = 1'b0;
      acc_d = '0;
      pc_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= OFF;
      wait_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      cd_q     <= 1'b0;
      insync_q <= 1'b0;
      ovf_q    <= 1'b0;
      vs_q     <= 1'b0;
      pv_q     <= 1'b0;
      pp_q     <= '0;
      acc_q    <= '0;
      pc_q     <= '0;
      fc_q     <= '0;
      rd_q     <= 1'b0;
      wp_q     <= 1'b0;
      mem_q    <= '{default: '0};
      for (int i = 0; i < 4; i++) pal_q[i] <= BPP'((i * ((1 << BPP) - 1)) / 3);
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      cd_q     <= cd_d;
      insync_q <= insync_d;
      ovf_q    <= ovf_d;
      vs_q     <= vs_d;
      pv_q     <= pv_d;
      pp_q     <= pp_d;
      acc_q    <= acc_d;
      pc_q     <= pc_d;
      fc_q     <= fc_d;
      rd_q     <= rd_d;
      wp_q     <= wp_d;
      mem_q    <= mem_d;
      pal_q    <= pal_d;
    end
  end

  assign init_addr = idx_q;
  assign lcd_data  = data_q;
  assign lcd_write = wr_q;
  assign lcd_cd    = cd_q;
  assign lcd_read  = 1'b0;
  assign lcd_cs    = 1'b1;
  assign lcd_vled  = disp_on;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_lcd_gray_stream.sv
// tb_lcd_gray_stream: directed checks of power-up, packing, palette, overflow, frame restart and shutdown.
module tb_lcd_gray_stream;
  typedef struct {logic cd; logic [7:0] d; int t;} ev_t;
  typedef struct {logic [1:0] a; logic [1:0] b; logic [7:0] exp;} vec_t;

  logic clk = 1'b0, reset = 1'b1;
  logic disp_on = 1'b0, vsync = 1'b0, px_out = 1'b0, pal_we = 1'b0;
  logic [1:0] px = '0, pal_idx = '0;
  logic [3:0] pal_data = '0, m_addr;
  logic [7:0] m_data;
  logic m_wr, m_cd, m_rd, m_cs, m_vled, m_ovf;
  logic a_disp = 1'b0, a_pxo = 1'b0;
  logic [1:0] a_px = '0;
  logic [3:0] a_addr;
  logic [7:0] b_data;
  logic b_wr, b_cd, b_rd, b_cs, b_vled, b_ovf;
  logic m_wr_p = 1'b0, b_wr_p = 1'b0;
  int cyc = 0, tests = 0, fails = 0, t0, t_last, bad;
  ev_t qa[$], qb[$];
  vec_t vt[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_gray_stream #(.BPP(4), .INIT_LEN(16), .REINIT_IDX(12), .WAIT_CYCLES(8), .WR_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .disp_on(disp_on), .hsync(1'b0), .vsync(vsync), .px_out(px_out),
    .px(px), .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data), .init_addr(m_addr),
    .init_data(8'h10 + {4'h0, m_addr}), .lcd_data(m_data), .lcd_write(m_wr), .lcd_cd(m_cd),
    .lcd_read(m_rd), .lcd_cs(m_cs), .lcd_vled(m_vled), .overflow(m_ovf));

  lcd_gray_stream #(.BPP(2), .INIT_LEN(16), .REINIT_IDX(12), .WAIT_CYCLES(8), .WR_CYCLES(4)) aux (
    .clk(clk), .reset(reset), .disp_on(a_disp), .hsync(1'b0), .vsync(1'b0), .px_out(a_pxo),
    .px(a_px), .pal_we(1'b0), .pal_idx(2'b0), .pal_data(2'b0), .init_addr(a_addr),
    .init_data(8'h10 + {4'h0, a_addr}), .lcd_data(b_data), .lcd_write(b_wr), .lcd_cd(b_cd),
    .lcd_read(b_rd), .lcd_cs(b_cs), .lcd_vled(b_vled), .overflow(b_ovf));

  always @(negedge clk) begin
    if (m_wr && !m_wr_p) qa.push_back('{m_cd, m_data, cyc});
    if (b_wr && !b_wr_p) qb.push_back('{b_cd, b_data, cyc});
    m_wr_p = m_wr;
    b_wr_p = b_wr;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic px2(input logic [1:0] a, input logic [1:0] b);
    @(posedge clk); #1 px_out = 1'b1; px = a;
    @(posedge clk); #1 px = b; t_last = cyc;
    @(posedge clk); #1 px_out = 1'b0;
  endtask

  initial begin
    vt[0] = '{2'd1, 2'd2, 8'hA5};
    vt[1] = '{2'd0, 2'd3, 8'hF0};
    vt[2] = '{2'd3, 2'd0, 8'h0F};
    vt[3] = '{2'd2, 2'd1, 8'h5A};
    vt[4] = '{2'd3, 2'd3, 8'hFF};
    vt[5] = '{2'd0, 2'd1, 8'h50};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst write", m_wr, 0);
    chk("rst cd", m_cd, 0);
    chk("rst data", m_data, 0);
    chk("rst addr", m_addr, 0);
    chk("rst ovf", m_ovf, 0);
    chk("rst read/cs/vled", {m_rd, m_cs, m_vled}, 3'b010);
    #1 reset = 1'b0;

    // power-up: 16 commands after an 8-cycle wait
    qa.delete();
    @(posedge clk); #1 disp_on = 1'b1; t0 = cyc;
    for (int i = 0; i < 200 && qa.size() < 16; i++) @(posedge clk);
    chk("pu count", qa.size(), 16);
    chk("pu first rise", qa[0].t, t0 + 10);
    chk("pu span", qa[15].t - qa[0].t, 30);
    for (int i = 0; i < 16; i++) chk($sformatf("pu cmd %0d", i), {qa[i].cd, qa[i].d}, {1'b0, 8'h10 + 8'(i)});
    repeat (4) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      qa.delete();
      px2(vt[i].a, vt[i].b);
      repeat (4) @(posedge clk);
      chk($sformatf("pack %0d count", i), qa.size(), 1);
      chk($sformatf("pack %0d byte", i), {qa[0].cd, qa[0].d}, {1'b1, vt[i].exp});
      if (i == 0) chk("pixel latency", qa[0].t, t_last + 3);
    end

    qa.delete();
    @(posedge clk); #1 pal_we = 1'b1; pal_idx = 2'd2; pal_data = 4'h7;
    @(posedge clk); #1 pal_we = 1'b0;
    px2(2'd2, 2'd2);
    repeat (4) @(posedge clk);
    chk("palette byte", {qa[0].cd, qa[0].d}, {1'b1, 8'h77});

    // frame restart with a half-filled byte pending
    qa.delete();
    @(posedge clk); #1 px_out = 1'b1; px = 2'd1;
    @(posedge clk); #1 px_out = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1 vsync = 1'b0;
    for (int i = 0; i < 50 && qa.size() < 4; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    px2(2'd1, 2'd3);
    repeat (4) @(posedge clk);
    chk("restart count", qa.size(), 5);
    for (int i = 0; i < 4; i++) chk($sformatf("restart cmd %0d", i), {qa[i].cd, qa[i].d}, {1'b0, 8'h1C + 8'(i)});
    chk("restart pixel", {qa[4].cd, qa[4].d}, {1'b1, 8'hF5});

    // shutdown while a pixel strobe is high
    qa.delete();
    px2(2'd0, 2'd3);
    repeat (2) @(posedge clk);
    #1 disp_on = 1'b0;
    @(negedge clk);
    chk("vled off", m_vled, 0);
    chk("inflight write", m_wr, 1);
    repeat (20) @(posedge clk);
    chk("shutdown count", qa.size(), 2);
    chk("shutdown pixel", {qa[0].cd, qa[0].d}, {1'b1, 8'hF0});
    chk("shutdown E2", {qa[1].cd, qa[1].d}, {1'b0, 8'hE2});
    chk("shutdown idle", m_wr, 0);

    // reset in the middle of init
    qa.delete();
    @(posedge clk); #1 disp_on = 1'b1;
    for (int i = 0; i < 100 && qa.size() < 3; i++) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst write", m_wr, 0);
    chk("midrst data", m_data, 0);
    chk("midrst addr", m_addr, 0);
    disp_on = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst strobes", qa.size(), 3);

    // BPP=2, WR_CYCLES=4 instance: packing then overflow
    @(posedge clk); #1 a_disp = 1'b1;
    for (int i = 0; i < 400 && qb.size() < 16; i++) @(posedge clk);
    chk("aux init count", qb.size(), 16);
    repeat (12) @(posedge clk);
    qb.delete();
    @(posedge clk); #1 a_pxo = 1'b1; a_px = 2'd3;
    @(posedge clk); #1 a_px = 2'd0;
    @(posedge clk); #1 a_px = 2'd1;
    @(posedge clk); #1 a_px = 2'd2;
    @(posedge clk); #1 a_pxo = 1'b0;
    repeat (10) @(posedge clk);
    chk("bpp2 count", qb.size(), 1);
    chk("bpp2 byte", {qb[0].cd, qb[0].d}, {1'b1, 8'h93});
    chk("bpp2 no ovf", b_ovf, 0);
    qb.delete();
    @(posedge clk); #1 a_pxo = 1'b1; a_px = 2'd3;
    repeat (40) @(posedge clk);
    #1 a_pxo = 1'b0;
    repeat (40) @(posedge clk);
    chk("ovf set", b_ovf, 1);
    chk("ovf partial drain", qb.size() > 2 && qb.size() < 10, 1);
    bad = 0;
    foreach (qb[i]) if ({qb[i].cd, qb[i].d} != 9'h1FF) bad++;
    chk("ovf whole bytes", bad, 0);
    qb.delete();
    @(posedge clk); #1 a_disp = 1'b0;
    repeat (20) @(posedge clk);
    chk("aux E2", {qb[0].cd, qb[0].d}, {1'b0, 8'hE2});
    chk("ovf sticky off", b_ovf, 1);
    @(posedge clk); #1 a_disp = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ovf cleared", b_ovf, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
